// File: rtl/dmd_video_sampler.sv
// rtl/dmd_video_sampler.sv - DMD video link receiver: timing measurement and per-cell pixel sampler
module dmd_video_sampler #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 390,
  parameter int CELL_W   = 10,
  parameter int CELL_H   = 10,
  parameter int DMD_W    = 128,
  parameter int DMD_H    = 39,
  parameter int SAMPLE_X = 5,
  parameter int SAMPLE_Y = 5,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              timing_err,
  output logic [11:0]       meas_width,
  output logic [11:0]       meas_height,
  output logic [11:0]       meas_htotal
);

  localparam int CXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int CYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int CW  = $clog2(DMD_W + 1);
  localparam int RW  = $clog2(DMD_H + 1);

  localparam logic [CXW-1:0]    CX_LAST  = CXW'(CELL_W - 1);
  localparam logic [CYW-1:0]    CY_LAST  = CYW'(CELL_H - 1);
  localparam logic [CXW-1:0]    SX       = CXW'(SAMPLE_X);
  localparam logic [CYW-1:0]    SY       = CYW'(SAMPLE_Y);
  localparam logic [CW-1:0]     COL_MAX  = CW'(DMD_W);
  localparam logic [RW-1:0]     ROW_MAX  = RW'(DMD_H);
  localparam logic [RW-1:0]     ROW_LAST = RW'(DMD_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(DMD_W);
  localparam logic [11:0]       H_EXP    = 12'(H_ACTIVE);
  localparam logic [11:0]       V_EXP    = 12'(V_ACTIVE);
  localparam logic [11:0]       CNT_SAT  = 12'hFFF;

  logic              de1, de2, hs1, hs2, vs1, vs2;
  logic [23:0]       rgb1, rgb2;
  logic              armed, bad, hs_seen;
  logic [11:0]       x_pix, line_cnt, hcnt;
  logic [CXW-1:0]    cell_x;
  logic [CYW-1:0]    cell_y;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] row_base;
  logic [1:0]        good_cnt;

  logic        de_rise, de_fall, hs_rise, vs_rise;
  logic [11:0] width_now, line_next;
  logic        bad_next, frame_good, sample_hit;
  logic [1:0]  good_cnt_inc;

  // Counters describe the pixel held in stage 2, so a DE fall still counts into its own line.
  always_comb begin
    de_rise      = de1 & ~de2;
    de_fall      = ~de1 & de2;
    hs_rise      = hs1 & ~hs2;
    vs_rise      = vs1 & ~vs2;
    width_now    = (x_pix == CNT_SAT) ? x_pix : x_pix + 12'd1;
    line_next    = (de_fall && line_cnt != CNT_SAT) ? line_cnt + 12'd1 : line_cnt;
    bad_next     = bad | (de_fall & (width_now != H_EXP));
    frame_good   = (line_next == V_EXP) && !bad_next;
    good_cnt_inc = (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
    sample_hit   = armed && de2 && (cell_x == SX) && (cell_y == SY) &&
                   (col < COL_MAX) && (row < ROW_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1 <= 1'b0; de2 <= 1'b0; hs1 <= 1'b0; hs2 <= 1'b0; vs1 <= 1'b0; vs2 <= 1'b0;
      rgb1 <= '0; rgb2 <= '0;
      armed <= 1'b0; bad <= 1'b0; hs_seen <= 1'b0;
      x_pix <= '0; line_cnt <= '0; hcnt <= '0;
      cell_x <= '0; cell_y <= '0; col <= '0; row <= '0; row_base <= '0;
      good_cnt <= '0;
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
      frame_done <= 1'b0; locked <= 1'b0; timing_err <= 1'b0;
      meas_width <= '0; meas_height <= '0; meas_htotal <= '0;
    end else begin
      de1 <= de_in; de2 <= de1;
      hs1 <= hsync_in; hs2 <= hs1;
      vs1 <= vsync_in; vs2 <= vs1;
      rgb1 <= {red_in, green_in, blue_in};
      rgb2 <= rgb1;

      wr_en <= sample_hit;
      if (sample_hit) begin
        wr_addr <= row_base + ADDR_W'(col);
        wr_data <= rgb2;
      end
      frame_done <= vs_rise & armed;

      if (de_rise) begin
        x_pix  <= '0;
        cell_x <= '0;
        col    <= '0;
      end else if (de1 && de2) begin
        if (x_pix != CNT_SAT) x_pix <= x_pix + 12'd1;
        if (cell_x == CX_LAST) begin
          cell_x <= '0;
          if (col != COL_MAX) col <= col + CW'(1);
        end else begin
          cell_x <= cell_x + CXW'(1);
        end
      end

      if (de_fall) begin
        meas_width <= width_now;
        bad        <= bad_next;
        line_cnt   <= line_next;
        if (cell_y == CY_LAST) begin
          cell_y <= '0;
          if (row < ROW_MAX) row <= row + RW'(1);
          // Stop advancing the base once past the last row so it can never overflow.
          if (row < ROW_LAST) row_base <= row_base + ROW_STEP;
        end else begin
          cell_y <= cell_y + CYW'(1);
        end
      end

      // Frame restart overrides any line bookkeeping from a coincident DE fall.
      if (vs_rise) begin
        armed    <= 1'b1;
        line_cnt <= '0;
        cell_y   <= '0;
        row      <= '0;
        row_base <= '0;
        bad      <= 1'b0;
        if (armed) begin
          meas_height <= line_next;
          if (frame_good) begin
            timing_err <= 1'b0;
            good_cnt   <= good_cnt_inc;
            locked     <= (good_cnt_inc == 2'd2);
          end else begin
            timing_err <= 1'b1;
            good_cnt   <= '0;
            locked     <= 1'b0;
          end
        end
      end

      if (hs_rise) begin
        hcnt    <= 12'd1;
        hs_seen <= 1'b1;
        if (hs_seen) meas_htotal <= hcnt;
      end else if (hcnt != CNT_SAT) begin
        hcnt <= hcnt + 12'd1;
      end
    end
  end

endmodule
